// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes, ALUControl codes and the request-kind enum.
package mips_pkg;

  typedef enum logic [1:0] {
    KIND_R  = 2'b00,
    KIND_I  = 2'b01,
    KIND_LW = 2'b10,
    KIND_SW = 2'b11
  } kind_e;

  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULTU = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1010;
  localparam logic [3:0] ALU_XOR   = 4'b1011;
  localparam logic [3:0] ALU_SLL   = 4'b1100;
  localparam logic [3:0] ALU_SRL   = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1110;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_MULTU  = 6'b011001;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_XOR    = 6'b100110;
  localparam logic [5:0] FN_SLL    = 6'b000000;
  localparam logic [5:0] FN_SRL    = 6'b000010;
  localparam logic [5:0] FN_SRA    = 6'b000011;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/instr_fields_enc.sv
// Combinational field packer: maps kind/op/register fields to a MIPS word plus a legality flag.
module instr_fields_enc
  import mips_pkg::*;
(
  input  kind_e       i_kind,
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  output logic        o_legal,
  output logic [31:0] o_word
);

  logic [5:0] w_funct;
  logic [5:0] w_iopc;
  logic       w_flegal;
  logic       w_ilegal;

  always_comb begin
    w_funct  = FN_ADD;
    w_flegal = 1'b1;
    unique case (i_op)
      ALU_ADD:   w_funct = FN_ADD;
      ALU_SUB:   w_funct = FN_SUB;
      ALU_MULTU: w_funct = FN_MULTU;
      ALU_OR:    w_funct = FN_OR;
      ALU_AND:   w_funct = FN_AND;
      ALU_XOR:   w_funct = FN_XOR;
      ALU_SLL:   w_funct = FN_SLL;
      ALU_SRL:   w_funct = FN_SRL;
      ALU_SRA:   w_funct = FN_SRA;
      default:   w_flegal = 1'b0;
    endcase
  end

  always_comb begin
    w_iopc   = OPC_ADDI;
    w_ilegal = 1'b1;
    unique case (i_op)
      ALU_ADD: w_iopc = OPC_ADDI;
      ALU_AND: w_iopc = OPC_ANDI;
      ALU_OR:  w_iopc = OPC_ORI;
      ALU_XOR: w_iopc = OPC_XORI;
      default: w_ilegal = 1'b0;
    endcase
  end

  always_comb begin
    o_legal = 1'b0;
    o_word  = 32'd0;
    unique case (i_kind)
      KIND_R: begin
        o_legal = w_flegal;
        // Shifts take no rs operand; everything else takes no shift amount.
        if (is_shift(i_op))
          o_word = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, w_funct};
        else
          o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, w_funct};
      end
      KIND_I: begin
        o_legal = w_ilegal;
        o_word  = {w_iopc, i_rs, i_rt, i_imm};
      end
      KIND_LW: begin
        o_legal = (i_op == ALU_ADD);
        o_word  = {OPC_LW, i_rs, i_rt, i_imm};
      end
      KIND_SW: begin
        o_legal = (i_op == ALU_ADD);
        o_word  = {OPC_SW, i_rs, i_rt, i_imm};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a single-entry output register and auto-incrementing write pointer.
// Optional illegal-request counter enabled by defining INSTR_ENC_ILLEGAL_CNT_EN.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        kind,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              imem_valid,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
`ifdef INSTR_ENC_ILLEGAL_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              err_pulse
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic              w_legal_p0;
  logic [31:0]       w_word_p0;
  logic              w_accept_p0;
  logic              w_done_p1;
  logic              r_vld_p1;
  logic [31:0]       r_wdata_p1;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_err_p1;

  instr_fields_enc u_fields (
    .i_kind  (kind_e'(kind)),
    .i_op    (op),
    .i_rs    (rs),
    .i_rt    (rt),
    .i_rd    (rd),
    .i_shamt (shamt),
    .i_imm   (imm),
    .o_legal (w_legal_p0),
    .o_word  (w_word_p0)
  );

  assign in_ready    = !r_vld_p1 || imem_ready;
  assign w_accept_p0 = in_valid && in_ready;
  assign w_done_p1   = r_vld_p1 && imem_ready;

  // p0 -> p1: accepted request lands in the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_wdata_p1 <= 32'd0;
      r_ptr      <= '0;
      r_err_p1   <= 1'b0;
    end else begin
      r_err_p1 <= w_accept_p0 && !w_legal_p0;
      if (w_accept_p0 && w_legal_p0) begin
        r_vld_p1   <= 1'b1;
        r_wdata_p1 <= w_word_p0;
      end else if (w_done_p1) begin
        r_vld_p1 <= 1'b0;
      end
      // A load retargets even a pending word, and wins over the post-write increment.
      if (addr_load)
        r_ptr <= addr_in;
      else if (w_done_p1)
        r_ptr <= r_ptr + PTR_ONE;
    end
  end

`ifdef INSTR_ENC_ILLEGAL_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_err_cnt <= 8'd0;
    else if (w_accept_p0 && !w_legal_p0 && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_count = r_err_cnt;
`endif

  assign imem_valid = r_vld_p1;
  assign imem_wdata = r_wdata_p1;
  assign imem_addr  = r_ptr;
  assign err_pulse  = r_err_p1;

endmodule
